mmio_bus_ctrl: RTL and testbench

//   Memory/IO bus controller directly downstream of the processor core. It consumes the core's

---
 rtl/mmio_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: word-addressed bus decoder between the core and RAM, LEDs, switches and timer.
// The interval timer on page 0x5 is present only when MMIO_TIMER_EN is defined.
module mmio_bus_ctrl #(
  parameter int RAM_AW         = 12,
  parameter int TIMER_PRESCALE = 50
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  output logic [15:0]       DIN,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [9:0]        SW,
  output logic [9:0]        LEDR,
  output logic              timer_irq
);

  localparam logic [3:0] PAGE_RAM = 4'h0;
  localparam logic [3:0] PAGE_LED = 4'h1;
  localparam logic [3:0] PAGE_SW  = 4'h3;

  typedef enum logic [2:0] {
    SEL_UNMAPPED = 3'd0,
    SEL_RAM      = 3'd1,
    SEL_LED      = 3'd2,
    SEL_SW       = 3'd3,
    SEL_TIMER    = 3'd4
  } sel_t;

  logic [3:0]  page_s;
  sel_t        sel_s;
  sel_t        sel_r;
  logic [15:0] per_s;
  logic [15:0] per_r;
  logic [9:0]  led_r;
  logic [9:0]  sw_meta_r;
  logic [9:0]  sw_sync_r;

  assign page_s    = ADDR[15:12];
  assign ram_addr  = ADDR[RAM_AW-1:0];
  assign ram_wdata = DOUT;
  assign ram_we    = W & (page_s == PAGE_RAM);
  assign LEDR      = led_r;
  // RAM data arrives registered from the external block RAM; everything else from per_r.
  assign DIN       = (sel_r == SEL_RAM) ? ram_rdata : per_r;

`ifdef MMIO_TIMER_EN
  localparam logic [3:0] PAGE_TMR = 4'h5;
  localparam int PS_W = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TIMER_PRESCALE - 1);

  logic [15:0]     load_r;
  logic [15:0]     count_r;
  logic [2:0]      ctrl_r;
  logic            expired_r;
  logic [PS_W-1:0] ps_r;
  logic [15:0]     timer_rd_s;
  logic            tmr_wr_s;
  logic            load_wr_s;
  logic            ctrl_wr_s;
  logic            status_wr_s;
  logic            tick_s;
  logic            expire_s;

  assign tmr_wr_s    = W & (page_s == PAGE_TMR);
  assign load_wr_s   = tmr_wr_s & (ADDR[1:0] == 2'd0);
  assign ctrl_wr_s   = tmr_wr_s & (ADDR[1:0] == 2'd2);
  assign status_wr_s = tmr_wr_s & (ADDR[1:0] == 2'd3);
  // A CTRL write restarts the prescaler, so no tick is taken on that edge.
  assign tick_s      = ctrl_r[0] & (ps_r == PS_LAST) & ~ctrl_wr_s;
  assign expire_s    = tick_s & ~load_wr_s & (count_r == 16'h0001);
  assign timer_irq   = expired_r & ctrl_r[2];

  // Timer register read mux
  always_comb begin
    timer_rd_s = 16'h0000;
    case (ADDR[1:0])
      2'd0:    timer_rd_s = load_r;
      2'd1:    timer_rd_s = count_r;
      2'd2:    timer_rd_s = {13'h0000, ctrl_r};
      2'd3:    timer_rd_s = {15'h0000, expired_r};
      default: timer_rd_s = 16'h0000;
    endcase
  end

  // Timer state: prescaler, down-counter, control and sticky expired flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      load_r    <= 16'h0000;
      count_r   <= 16'h0000;
      ctrl_r    <= 3'b000;
      expired_r <= 1'b0;
      ps_r      <= {PS_W{1'b0}};
    end else begin
      if (ctrl_wr_s) begin
        ps_r <= {PS_W{1'b0}};
      end else if (ctrl_r[0]) begin
        ps_r <= (ps_r == PS_LAST) ? {PS_W{1'b0}} : ps_r + PS_W'(1'b1);
      end
      if (load_wr_s) begin
        load_r <= DOUT;
      end
      if (ctrl_wr_s) begin
        ctrl_r <= DOUT[2:0];
      end
      if (load_wr_s) begin
        count_r <= DOUT;
      end else if (tick_s) begin
        if (count_r != 16'h0000) begin
          count_r <= count_r - 16'h0001;
        end else if (ctrl_r[1]) begin
          count_r <= load_r;
        end
      end
      // Set beats a simultaneous write-1-to-clear.
      if (expire_s) begin
        expired_r <= 1'b1;
      end else if (status_wr_s && DOUT[0]) begin
        expired_r <= 1'b0;
      end
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // Page decode and peripheral read data, using pre-write register values
  always_comb begin
    sel_s = SEL_UNMAPPED;
    per_s = 16'h0000;
    case (page_s)
      PAGE_RAM: begin
        sel_s = SEL_RAM;
        per_s = 16'h0000;
      end
      PAGE_LED: begin
        sel_s = SEL_LED;
        per_s = {6'h00, led_r};
      end
      PAGE_SW: begin
        sel_s = SEL_SW;
        per_s = {6'h00, sw_sync_r};
      end
`ifdef MMIO_TIMER_EN
      PAGE_TMR: begin
        sel_s = SEL_TIMER;
        per_s = timer_rd_s;
      end
`endif
      default: begin
        sel_s = SEL_UNMAPPED;
        per_s = 16'h0000;
      end
    endcase
  end

  // Read-path registers giving one cycle of latency on every page
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_r <= SEL_UNMAPPED;
      per_r <= 16'h0000;
    end else begin
      sel_r <= sel_s;
      per_r <= per_s;
    end
  end

  // LED register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_r <= 10'h000;
    end else if (W && (page_s == PAGE_LED)) begin
      led_r <= DOUT[9:0];
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta_r <= 10'h000;
      sw_sync_r <= 10'h000;
    end else begin
      sw_meta_r <= SW;
      sw_sync_r <= sw_meta_r;
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: directed cases plus random traffic scored
// against a transaction-level model of the memory map (timer checks need MMIO_TIMER_EN).
module tb_mmio_bus_ctrl;

  localparam int TB_PS = 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  mmio_bus_ctrl #(.RAM_AW(12), .TIMER_PRESCALE(TB_PS)) dut (
    .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .SW(SW), .LEDR(LEDR), .timer_irq(timer_irq)
  );

  // External synchronous block RAM, read-first
  logic [15:0] ram_mem [0:4095];
  always @(posedge Clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state
  logic [15:0] m_mem [int];
  logic [9:0]  sw_hist [int];
  logic [9:0]  m_led = 10'h000;
  int          edge_n = 0;
  int          last_rst = -10;
  logic [15:0] m_load = 16'h0000;
  logic [15:0] m_count = 16'h0000;
  logic [2:0]  m_ctrl = 3'b000;
  logic        m_expired = 1'b0;
  int          m_ps = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, input int k);
    logic [15:0] r;
    r = 16'h0000;
    case (a[15:12])
      4'h0: r = m_mem.exists(int'(a[11:0])) ? m_mem[int'(a[11:0])] : 16'h0000;
      4'h1: r = {6'h00, m_led};
      4'h3: r = ((k - 2 > last_rst) && sw_hist.exists(k - 2)) ? {6'h00, sw_hist[k - 2]} : 16'h0000;
`ifdef MMIO_TIMER_EN
      4'h5: begin
        case (a[1:0])
          2'd0:    r = m_load;
          2'd1:    r = m_count;
          2'd2:    r = {13'h0000, m_ctrl};
          default: r = {15'h0000, m_expired};
        endcase
      end
`endif
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // One bus cycle: drive, predict, clock, compare
  task automatic bus_cycle(input logic rst, input logic [15:0] a, input logic [15:0] d, input logic w);
    logic [15:0] exp_din;
    logic        lw, cw, stw, tick, expire;
    logic [15:0] nxt_count;
    Reset = rst; ADDR = a; DOUT = d; W = w;
    sw_hist[edge_n] = SW;
    #1;
    check_val("ram_we", {15'h0000, ram_we}, {15'h0000, (w && (a[15:12] == 4'h0))});
    if (rst) begin
      exp_din = 16'h0000;
      m_led = 10'h000;
      m_load = 16'h0000; m_count = 16'h0000; m_ctrl = 3'b000; m_expired = 1'b0; m_ps = 0;
      last_rst = edge_n;
    end else begin
      exp_din = model_read(a, edge_n);
      if (w && a[15:12] == 4'h0) m_mem[int'(a[11:0])] = d;
      if (w && a[15:12] == 4'h1) m_led = d[9:0];
`ifdef MMIO_TIMER_EN
      lw  = w && (a[15:12] == 4'h5) && (a[1:0] == 2'd0);
      cw  = w && (a[15:12] == 4'h5) && (a[1:0] == 2'd2);
      stw = w && (a[15:12] == 4'h5) && (a[1:0] == 2'd3);
      tick = m_ctrl[0] && (m_ps == TB_PS - 1) && !cw;
      expire = 1'b0;
      nxt_count = m_count;
      if (lw) nxt_count = d;
      else if (tick) begin
        if (m_count != 16'h0000) begin
          nxt_count = m_count - 16'h0001;
          expire = (m_count == 16'h0001);
        end else if (m_ctrl[1]) nxt_count = m_load;
      end
      if (cw) m_ps = 0;
      else if (m_ctrl[0]) m_ps = (m_ps + 1) % TB_PS;
      if (expire) m_expired = 1'b1;
      else if (stw && d[0]) m_expired = 1'b0;
      m_count = nxt_count;
      if (lw) m_load = d;
      if (cw) m_ctrl = d[2:0];
`else
      lw = 1'b0; cw = 1'b0; stw = 1'b0; tick = 1'b0; expire = 1'b0; nxt_count = 16'h0000;
`endif
    end
    @(posedge Clock);
    #1;
    edge_n++;
    check_val("din", DIN, exp_din);
    check_val("ledr", {6'h00, LEDR}, {6'h00, m_led});
    check_val("timer_irq", {15'h0000, timer_irq}, {15'h0000, (m_expired & m_ctrl[2])});
  endtask

  initial begin
    SW = 10'h000;
    bus_cycle(1'b1, 16'h0000, 16'h0000, 1'b0);
    bus_cycle(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_val("rst_din", DIN, 16'h0000);
    check_val("rst_ledr", {6'h00, LEDR}, 16'h0000);
    for (int i = 0; i < 16; i++) bus_cycle(1'b0, 16'(i), 16'h0000, 1'b1);

    // RAM write then read back
    bus_cycle(1'b0, 16'h0012, 16'hBEEF, 1'b1);
    bus_cycle(1'b0, 16'h0012, 16'h0000, 1'b0);
    check_val("ram_readback", DIN, 16'hBEEF);

    // LED write, read, reset with concurrent write
    bus_cycle(1'b0, 16'h1000, 16'h03FF, 1'b1);
    check_val("led_write", {6'h00, LEDR}, 16'h03FF);
    bus_cycle(1'b0, 16'h1000, 16'h0000, 1'b0);
    check_val("led_read", DIN, 16'h03FF);
    bus_cycle(1'b1, 16'h1000, 16'h0155, 1'b1);
    check_val("led_reset", {6'h00, LEDR}, 16'h0000);
    check_val("reset_inflight", DIN, 16'h0000);

    // Switches through the synchroniser, unmapped page
    SW = 10'h155;
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 16'h2000, 16'h0000, 1'b0);
    bus_cycle(1'b0, 16'h3000, 16'h0000, 1'b0);
    check_val("sw_read", DIN, 16'h0155);
    bus_cycle(1'b0, 16'h7000, 16'hFFFF, 1'b1);
    check_val("unmapped_read", DIN, 16'h0000);

`ifdef MMIO_TIMER_EN
    bus_cycle(1'b0, 16'h5000, 16'h0003, 1'b1);
    bus_cycle(1'b0, 16'h5002, 16'h0003, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
      check_val("tmr_count", DIN, 16'(3 - i));
    end
    bus_cycle(1'b0, 16'h5003, 16'h0000, 1'b0);
    check_val("tmr_expired", DIN, 16'h0001);
    bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
    check_val("tmr_reloaded", DIN, 16'h0002);
    bus_cycle(1'b0, 16'h5003, 16'h0001, 1'b1);
    bus_cycle(1'b0, 16'h5003, 16'h0000, 1'b0);
    check_val("tmr_set_wins", DIN, 16'h0001);
    bus_cycle(1'b0, 16'h5003, 16'h0001, 1'b1);
    bus_cycle(1'b0, 16'h5003, 16'h0000, 1'b0);
    check_val("tmr_cleared", DIN, 16'h0000);

    bus_cycle(1'b0, 16'h5002, 16'h0000, 1'b1);
    bus_cycle(1'b0, 16'h5003, 16'h0001, 1'b1);
    bus_cycle(1'b0, 16'h5000, 16'h0002, 1'b1);
    bus_cycle(1'b0, 16'h5002, 16'h0005, 1'b1);
    check_val("irq_idle", {15'h0000, timer_irq}, 16'h0000);
    bus_cycle(1'b0, 16'h2000, 16'h0000, 1'b0);
    bus_cycle(1'b0, 16'h2000, 16'h0000, 1'b0);
    check_val("irq_fire", {15'h0000, timer_irq}, 16'h0001);
    bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
    bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
    check_val("tmr_hold0", DIN, 16'h0000);
    bus_cycle(1'b0, 16'h5002, 16'h0000, 1'b1);
    bus_cycle(1'b0, 16'h5000, 16'h0005, 1'b1);
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 16'h2000, 16'h0000, 1'b0);
    bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
    check_val("tmr_frozen", DIN, 16'h0005);
`else
    bus_cycle(1'b0, 16'h5001, 16'h0000, 1'b0);
    check_val("no_tmr_read", DIN, 16'h0000);
    bus_cycle(1'b0, 16'h5002, 16'h0007, 1'b1);
    bus_cycle(1'b0, 16'h5003, 16'h0000, 1'b0);
    check_val("no_tmr_read2", DIN, 16'h0000);
    check_val("no_tmr_irq", {15'h0000, timer_irq}, 16'h0000);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  pg;
      logic [15:0] a, d;
      logic        w, rst;
      case ($urandom_range(0, 7))
        0, 1:    pg = 4'h0;
        2:       pg = 4'h1;
        3:       pg = 4'h3;
        4, 5:    pg = 4'h5;
        default: pg = 4'($urandom_range(2, 15));
      endcase
      a   = {pg, 8'h00, 4'($urandom_range(0, 15))};
      d   = (pg == 4'h5) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      w   = !rst && ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      bus_cycle(rst, a, d, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
